// File: rtl/mac_pe_pkg.sv
// mac_pe_pkg: shared types and helpers for the mac_pe processing element.
//   state_e   one-hot FSM state encoding
//   ext       sign/zero extension of a w-bit value into a wide container
//   sat_add   w-bit add with overflow detection and clamped result
// The helpers work on a MAX_W-wide container with a run-time width so one
// definition serves every accumulator/product width the PE is built with.
package mac_pe_pkg;

  typedef enum logic [6:0] {
    IDLE   = 7'b0000001,
    A_HELD = 7'b0000010,
    B_HELD = 7'b0000100,
    MULT   = 7'b0001000,
    ACCUM  = 7'b0010000,
    FWD    = 7'b0100000,
    DRAIN  = 7'b1000000
  } state_e;

  localparam int MAX_W = 128;
  typedef logic [MAX_W-1:0] wide_t;

  typedef struct packed {
    logic  clamped;
    wide_t sum;
  } add_res_t;

  // Extend the low w bits of v to the full container width.
  function automatic wide_t ext(input wide_t v, input int w, input logic sgn);
    wide_t r;
    for (int i = 0; i < MAX_W; i++)
      r[i] = (i < w) ? v[i] : (sgn & v[w-1]);
    return r;
  endfunction

  // Add two w-bit values; on overflow the low w bits hold the nearest
  // representable extreme (signed max/min, or unsigned all-ones).
  function automatic add_res_t sat_add(input wide_t a, input wide_t b,
                                       input int w, input logic sgn);
    wide_t    s;
    add_res_t r;
    s         = ext(a, w, sgn) + ext(b, w, sgn);
    r.sum     = s;
    r.clamped = sgn ? (s[w] != s[w-1]) : s[w];
    if (r.clamped)
      for (int i = 0; i < MAX_W; i++)
        r.sum[i] = (i >= w) ? 1'b0 :
                   sgn      ? ((i == w-1) ? s[w] : ~s[w]) : 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mac_pe_if.sv
// mac_pe_if: operand, forwarding, flush and drain signals of one PE.
//   slave  - the PE's view (operands in, forwarded operands/result out)
//   master - the neighbour/driver view
interface mac_pe_if #(
  parameter int data_width_p  = 16,
  parameter int accum_width_p = 40
);
  logic                     en_i;
  logic                     a_valid_i, a_ready_o;
  logic [data_width_p-1:0]  a_i;
  logic                     b_valid_i, b_ready_o;
  logic [data_width_p-1:0]  b_i;
  logic                     a_valid_o, a_yumi_i;
  logic [data_width_p-1:0]  a_o;
  logic                     b_valid_o, b_yumi_i;
  logic [data_width_p-1:0]  b_o;
  logic                     flush_i, flush_o;
  logic                     accum_valid_o, accum_ready_i;
  logic [accum_width_p-1:0] accum_o;
  logic                     sat_o;

  modport slave (
    input  en_i, a_valid_i, a_i, b_valid_i, b_i, a_yumi_i, b_yumi_i,
           flush_i, accum_ready_i,
    output a_ready_o, b_ready_o, a_valid_o, a_o, b_valid_o, b_o,
           flush_o, accum_valid_o, accum_o, sat_o
  );

  modport master (
    output en_i, a_valid_i, a_i, b_valid_i, b_i, a_yumi_i, b_yumi_i,
           flush_i, accum_ready_i,
    input  a_ready_o, b_ready_o, a_valid_o, a_o, b_valid_o, b_o,
           flush_o, accum_valid_o, accum_o, sat_o
  );
endinterface

// File: rtl/mac_pe_accum.sv
// mac_pe_accum: registered accumulator for mac_pe.
//   clk, rst_n  clock / async active-low reset
//   clr         zero accumulator and saturation flag
//   add_en      add the extended product this cycle
//   product     2*data-width product
//   accum, sat  accumulator value and sticky saturation flag
// MAC_PE_SATURATE_EN defined: additions clamp and set sat; otherwise the
// accumulator wraps and sat is constant 0.
module mac_pe_accum
  import mac_pe_pkg::*;
#(
  parameter int accum_width_p = 40,
  parameter int prod_width_p  = 32,
  parameter bit signed_p      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     add_en,
  input  logic [prod_width_p-1:0]  product,
  output logic [accum_width_p-1:0] accum,
  output logic                     sat
);

  wide_t                    addend_w;
  logic [accum_width_p-1:0] addend;
  logic                     unused_hi;

  always_comb addend_w = ext(wide_t'(product), prod_width_p, signed_p);
  assign addend    = addend_w[accum_width_p-1:0];
  assign unused_hi = ^addend_w[MAX_W-1:accum_width_p];

`ifdef MAC_PE_SATURATE_EN
  add_res_t res;
  logic     unused_sum;

  always_comb res = sat_add(wide_t'(accum), wide_t'(addend), accum_width_p, signed_p);
  assign unused_sum = ^res.sum[MAX_W-1:accum_width_p];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      accum <= '0;
      sat   <= 1'b0;
    end else if (add_en) begin
      accum <= res.sum[accum_width_p-1:0];
      if (res.clamped) sat <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      accum <= '0;
    else if (clr)    accum <= '0;
    else if (add_en) accum <= accum + addend;
  end
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/mac_pe.sv
// mac_pe: systolic-array multiply-accumulate processing element.
//   clk_i, reset_n_i  clock / async active-low reset
//   io (mac_pe_if.slave):
//     en_i                          global stall (freezes state, gates handshakes)
//     a/b_valid_i, a/b_ready_o, a/b_i   operand capture (ready-valid)
//     a/b_valid_o, a/b_yumi_i, a/b_o    operand forwarding (valid-yumi)
//     flush_i, flush_o              drain request, registered copy to neighbour
//     accum_valid_o, accum_ready_i, accum_o, sat_o   drain result
// Optional macro MAC_PE_SATURATE_EN selects a saturating accumulator.
module mac_pe
  import mac_pe_pkg::*;
#(
  parameter int data_width_p  = 16,
  parameter int accum_width_p = 40,
  parameter bit signed_p      = 1'b1
) (
  input logic     clk_i,
  input logic     reset_n_i,
  mac_pe_if.slave io
);

  localparam int PW = 2 * data_width_p;

  if (accum_width_p < PW)
    $error("mac_pe: accum_width_p must be >= 2*data_width_p");
  if (accum_width_p >= MAX_W)
    $error("mac_pe: accum_width_p exceeds helper container width");

  state_e                  state;
  logic [data_width_p-1:0] a_r, b_r;
  logic [PW-1:0]           product_r, a_ext, b_ext;
  logic                    a_full, b_full, a_fwd_done, b_fwd_done;
  logic                    flush_pend_r, flush_r;
  logic                    en, in_load, a_cap, b_cap, a_yumi, b_yumi, drain_acc;

  assign en      = io.en_i;
  assign in_load = state inside {IDLE, A_HELD, B_HELD};

  // Ready is also masked by reset so every output reads 0 while held in reset.
  assign io.a_ready_o     = reset_n_i & en & in_load & ~a_full;
  assign io.b_ready_o     = reset_n_i & en & in_load & ~b_full;
  assign io.a_valid_o     = en & (state == FWD) & ~a_fwd_done;
  assign io.b_valid_o     = en & (state == FWD) & ~b_fwd_done;
  assign io.accum_valid_o = en & (state == DRAIN);
  assign io.a_o           = a_r;
  assign io.b_o           = b_r;
  assign io.flush_o       = flush_r;

  assign a_cap     = io.a_valid_i & io.a_ready_o;
  assign b_cap     = io.b_valid_i & io.b_ready_o;
  // yumi only counts while our own valid is up
  assign a_yumi    = io.a_yumi_i & io.a_valid_o;
  assign b_yumi    = io.b_yumi_i & io.b_valid_o;
  assign drain_acc = io.accum_valid_o & io.accum_ready_i;

  assign a_ext = signed_p ? {{data_width_p{a_r[data_width_p-1]}}, a_r}
                          : {{data_width_p{1'b0}}, a_r};
  assign b_ext = signed_p ? {{data_width_p{b_r[data_width_p-1]}}, b_r}
                          : {{data_width_p{1'b0}}, b_r};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      a_r          <= '0;
      b_r          <= '0;
      product_r    <= '0;
      a_full       <= 1'b0;
      b_full       <= 1'b0;
      a_fwd_done   <= 1'b0;
      b_fwd_done   <= 1'b0;
      flush_pend_r <= 1'b0;
      flush_r      <= 1'b0;
    end else begin
      flush_r <= io.flush_i & en;
      if (en) begin
        // a new flush during DRAIN re-arms the request even on accept
        if (io.flush_i)     flush_pend_r <= 1'b1;
        else if (drain_acc) flush_pend_r <= 1'b0;
        if (a_cap) begin a_r <= io.a_i; a_full <= 1'b1; end
        if (b_cap) begin b_r <= io.b_i; b_full <= 1'b1; end
        unique case (state)
          IDLE, A_HELD, B_HELD: begin
            // an arriving operand wins over a pending drain
            if ((a_full | a_cap) & (b_full | b_cap)) state <= MULT;
            else if (a_full | a_cap)                 state <= A_HELD;
            else if (b_full | b_cap)                 state <= B_HELD;
            else if (flush_pend_r)                   state <= DRAIN;
          end
          MULT: begin
            product_r <= a_ext * b_ext;
            state     <= ACCUM;
          end
          ACCUM: state <= FWD;
          FWD: begin
            if (a_yumi) a_fwd_done <= 1'b1;
            if (b_yumi) b_fwd_done <= 1'b1;
            if ((a_fwd_done | a_yumi) & (b_fwd_done | b_yumi)) begin
              state      <= IDLE;
              a_full     <= 1'b0;
              b_full     <= 1'b0;
              a_fwd_done <= 1'b0;
              b_fwd_done <= 1'b0;
            end
          end
          DRAIN: if (io.accum_ready_i) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  mac_pe_accum #(
    .accum_width_p(accum_width_p),
    .prod_width_p (PW),
    .signed_p     (signed_p)
  ) u_accum (
    .clk    (clk_i),
    .rst_n  (reset_n_i),
    .clr    (drain_acc),
    .add_en (en & (state == ACCUM)),
    .product(product_r),
    .accum  (io.accum_o),
    .sat    (io.sat_o)
  );

endmodule
